// File: rtl/pixel_canvas_pkg.sv
// ============================================================================
// Module      : pixel_pkg
// Description : Shared colour codes, FSM state type and canvas defaults.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pixel_pkg;

    localparam logic [2:0] c_COLOR_ERASE  = 3'b000;
    localparam logic [2:0] c_COLOR_RED    = 3'b001;
    localparam logic [2:0] c_COLOR_GREEN  = 3'b010;
    localparam logic [2:0] c_COLOR_BLUE   = 3'b011;
    localparam logic [2:0] c_COLOR_YELLOW = 3'b100;
    localparam logic [2:0] c_COLOR_PURPLE = 3'b101;

    localparam int c_CANVAS_BITS = 7;
    localparam int c_GRID_PITCH  = 50;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PAINT = 2'd1,
        CLEAR = 2'd2
    } canvas_state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_canvas_ram.sv
// ============================================================================
// Module      : canvas_ram
// Description : Simple dual-port read-first RAM, no reset (maps to EBR).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module canvas_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read and write in one block: a colliding read sees the pre-write word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

`default_nettype wire

// File: rtl/pixel_canvas.sv
// ============================================================================
// Module      : pixel_canvas
// Description : Paint framebuffer with clipped square brush, clear sweep and
//               registered VGA read port with grid overlay.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_canvas
    import pixel_pkg::*;
#(
    parameter int                 CANVAS_BITS = c_CANVAS_BITS,
    parameter int                 COLOR_W     = 3,
    parameter int                 SIZE_W      = 2,
    parameter int                 GRID_PITCH  = c_GRID_PITCH,
    parameter logic [COLOR_W-1:0] GRID_COLOR  = c_COLOR_PURPLE,
    parameter logic [COLOR_W-1:0] OUT_COLOR   = c_COLOR_ERASE,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = c_COLOR_ERASE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   brush_valid,
    output logic                   brush_ready,
    input  logic [CANVAS_BITS-1:0] brush_x,
    input  logic [CANVAS_BITS-1:0] brush_y,
    input  logic [COLOR_W-1:0]     brush_color,
    input  logic [SIZE_W-1:0]      brush_size,
    input  logic                   clear_req,
    output logic                   busy,
    input  logic [9:0]             rx,
    input  logic [9:0]             ry,
    output logic [COLOR_W-1:0]     colorCode
);

    localparam int c_ADDR_W = 2 * CANVAS_BITS;
    localparam logic [CANVAS_BITS-1:0] c_MAX = '1;
    localparam int c_GRID_LINES = (GRID_PITCH == 0) ? 0 :
        ((2**CANVAS_BITS) - 1) / ((GRID_PITCH == 0) ? 1 : GRID_PITCH);

    canvas_state_t          r_state;
    logic [CANVAS_BITS-1:0] r_cx, r_cy, r_xs, r_xe, r_ye;
    logic [COLOR_W-1:0]     r_color;

    logic [CANVAS_BITS-1:0] w_xs, w_xe, w_ys, w_ye;
    logic [CANVAS_BITS:0]   w_xe_full, w_ye_full;
    logic [CANVAS_BITS-1:0] w_s;

    // Saturating clip of the brush square against the canvas edges.
    always_comb begin
        w_s       = CANVAS_BITS'(brush_size);
        w_xs      = (brush_x >= w_s) ? (brush_x - w_s) : '0;
        w_ys      = (brush_y >= w_s) ? (brush_y - w_s) : '0;
        w_xe_full = {1'b0, brush_x} + {1'b0, w_s};
        w_ye_full = {1'b0, brush_y} + {1'b0, w_s};
        w_xe      = (w_xe_full > {1'b0, c_MAX}) ? c_MAX : w_xe_full[CANVAS_BITS-1:0];
        w_ye      = (w_ye_full > {1'b0, c_MAX}) ? c_MAX : w_ye_full[CANVAS_BITS-1:0];
    end

    assign brush_ready = (r_state == IDLE) && !clear_req && reset;
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cx    <= '0;
            r_cy    <= '0;
            r_xs    <= '0;
            r_xe    <= '0;
            r_ye    <= '0;
            r_color <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_req) begin
                        r_state <= CLEAR;
                        r_cx    <= '0;
                        r_cy    <= '0;
                    end else if (brush_valid) begin
                        r_state <= PAINT;
                        r_cx    <= w_xs;
                        r_cy    <= w_ys;
                        r_xs    <= w_xs;
                        r_xe    <= w_xe;
                        r_ye    <= w_ye;
                        r_color <= brush_color;
                    end
                end
                PAINT: begin
                    if (r_cx == r_xe) begin
                        r_cx <= r_xs;
                        if (r_cy == r_ye) begin
                            r_state <= IDLE;
                        end else begin
                            r_cy <= r_cy + 1'b1;
                        end
                    end else begin
                        r_cx <= r_cx + 1'b1;
                    end
                end
                CLEAR: begin
                    // The cursor pair doubles as the linear sweep address.
                    {r_cy, r_cx} <= {r_cy, r_cx} + 1'b1;
                    if (&{r_cy, r_cx}) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic               w_we;
    logic [COLOR_W-1:0] w_wdata;
    logic [COLOR_W-1:0] w_rdata;

    assign w_we    = (r_state != IDLE);
    assign w_wdata = (r_state == CLEAR) ? CLEAR_COLOR : r_color;

    canvas_ram #(
        .ADDR_W (c_ADDR_W),
        .DATA_W (COLOR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({r_cy, r_cx}),
        .i_wdata (w_wdata),
        .i_raddr ({ry[CANVAS_BITS-1:0], rx[CANVAS_BITS-1:0]}),
        .o_rdata (w_rdata)
    );

    logic [9:0]         r_rx_q, r_ry_q;
    logic               w_outside, w_grid;
    logic [COLOR_W-1:0] w_pix;

    // Grid test compares against the constant multiples of the pitch.
    always_comb begin
        w_outside = (int'(r_rx_q) >= (2**CANVAS_BITS)) || (int'(r_ry_q) >= (2**CANVAS_BITS));
        w_grid    = 1'b0;
        for (int k = 1; k <= c_GRID_LINES; k++) begin
            if ((int'(r_rx_q) == k * GRID_PITCH) || (int'(r_ry_q) == k * GRID_PITCH)) begin
                w_grid = 1'b1;
            end
        end
        if (w_outside) begin
            w_pix = OUT_COLOR;
        end else if (w_grid) begin
            w_pix = GRID_COLOR;
        end else begin
            w_pix = w_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rx_q    <= '0;
            r_ry_q    <= '0;
            colorCode <= OUT_COLOR;
        end else begin
            r_rx_q    <= rx;
            r_ry_q    <= ry;
            colorCode <= w_pix;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_canvas.sv
// ============================================================================
// Module      : tb_pixel_canvas
// Description : Directed self-checking bench for pixel_canvas.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_canvas;

    logic       clk;
    logic       reset;
    logic       brush_valid;
    logic       brush_ready;
    logic [6:0] brush_x;
    logic [6:0] brush_y;
    logic [2:0] brush_color;
    logic [1:0] brush_size;
    logic       clear_req;
    logic       busy;
    logic [9:0] rx;
    logic [9:0] ry;
    logic [2:0] colorCode;

    int r_tests;
    int r_fails;

    pixel_canvas u_dut (
        .clk         (clk),
        .reset       (reset),
        .brush_valid (brush_valid),
        .brush_ready (brush_ready),
        .brush_x     (brush_x),
        .brush_y     (brush_y),
        .brush_color (brush_color),
        .brush_size  (brush_size),
        .clear_req   (clear_req),
        .busy        (busy),
        .rx          (rx),
        .ry          (ry),
        .colorCode   (colorCode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        r_tests++;
        if (got != exp) begin
            r_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Busy cycles from the accepting edge until busy drops, bounded.
    task automatic count_busy(output int cnt);
        cnt = 1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #1;
            if (!busy) break;
            cnt++;
        end
    endtask

    task automatic read_px(input int x, input int y, input int exp);
        @(negedge clk);
        rx = 10'(x);
        ry = 10'(y);
        @(posedge clk);
        @(posedge clk);
        #1;
        check($sformatf("pix(%0d,%0d)", x, y), int'(colorCode), exp);
    endtask

    task automatic stroke(input int x, input int y, input int s, input int col);
        @(negedge clk);
        brush_valid = 1'b1;
        brush_x     = 7'(x);
        brush_y     = 7'(y);
        brush_size  = 2'(s);
        brush_color = 3'(col);
        @(posedge clk);
        #1;
        check("stroke_busy", int'(busy), 1);
        brush_valid = 1'b0;
    endtask

    int n;

    initial begin
        r_tests     = 0;
        r_fails     = 0;
        reset       = 1'b0;
        brush_valid = 1'b0;
        brush_x     = '0;
        brush_y     = '0;
        brush_color = '0;
        brush_size  = '0;
        clear_req   = 1'b0;
        rx          = '0;
        ry          = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(brush_ready), 0);
        check("rst_color", int'(colorCode), 0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("ready_after_rst", int'(brush_ready), 1);

        // Clear and stroke requested together: clear wins, stroke is held.
        @(negedge clk);
        clear_req   = 1'b1;
        brush_valid = 1'b1;
        brush_x     = 7'd10;
        brush_y     = 7'd20;
        brush_size  = 2'd1;
        brush_color = 3'b010;
        #1;
        check("ready_clear_prio", int'(brush_ready), 0);
        @(posedge clk);
        #1;
        check("clear_busy", int'(busy), 1);
        clear_req = 1'b0;
        count_busy(n);
        check("clear_cycles", n, 16384);
        check("ready_after_clear", int'(brush_ready), 1);
        @(posedge clk);
        #1;
        check("held_stroke_busy", int'(busy), 1);
        brush_valid = 1'b0;
        count_busy(n);
        check("paint9_cycles", n, 9);

        for (int y = 19; y <= 21; y++) begin
            for (int x = 9; x <= 11; x++) begin
                read_px(x, y, 2);
            end
        end
        read_px(12, 20, 0);
        read_px(8, 20, 0);
        read_px(0, 0, 0);
        read_px(50, 10, 5);
        read_px(10, 100, 5);
        read_px(100, 50, 5);
        read_px(200, 5, 0);
        read_px(200, 50, 0);
        read_px(5, 128, 0);

        // Corner stroke clipped to x 0..3, y 124..127.
        stroke(0, 127, 3, 4);
        count_busy(n);
        check("corner_cycles", n, 16);
        read_px(0, 127, 4);
        read_px(3, 124, 4);
        read_px(4, 124, 0);
        read_px(3, 123, 0);
        read_px(125, 124, 0);
        read_px(125, 127, 0);
        read_px(0, 2, 0);
        read_px(1, 1, 0);

        // Reset during the 4th paint cycle of a 5x5 stroke.
        stroke(30, 30, 2, 3);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_ready_in_rst", int'(brush_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ready_after", int'(brush_ready), 1);
        read_px(28, 28, 3);
        read_px(30, 28, 3);
        read_px(31, 28, 3);
        read_px(32, 28, 0);
        read_px(28, 29, 0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pixel_canvas.md
Name: pixel_canvas

Overview:
- Parametrised paint framebuffer. Successor to the fixed 128x128 single-pixel store.
- Accepts brush strokes through a valid/ready handshake and paints a clipped square of configurable size, one pixel per cycle.
- Supports a full-canvas clear sweep.
- Serves a registered read port to the VGA pixel path, with out-of-canvas fill and an optional grid overlay.
- Sits between the input/coordinate front end and the VGA colour/DAC stage.

Parameters:
- CANVAS_BITS, 7: canvas is 2^CANVAS_BITS x 2^CANVAS_BITS pixels (default 128x128).
- COLOR_W, 3: colour code width.
- SIZE_W, 2: width of brush_size. Half-width range is 0..2^SIZE_W-1.
- GRID_PITCH, 50: grid line spacing in pixels. 0 disables the grid.
- GRID_COLOR, 3'b101: overlay colour (purple code).
- OUT_COLOR, 3'b000: colour outside the canvas (erase code).
- CLEAR_COLOR, 3'b000: value written by a clear sweep.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- brush_valid  in  1  stroke request
- brush_ready  out  1  high when a stroke or clear can be accepted
- brush_x  in  CANVAS_BITS  stroke centre x
- brush_y  in  CANVAS_BITS  stroke centre y
- brush_color  in  COLOR_W  stroke colour
- brush_size  in  SIZE_W  half-width s; painted square is (2s+1)x(2s+1) before clipping
- clear_req  in  1  request a full-canvas clear
- busy  out  1  high while in PAINT or CLEAR
- rx  in  10  VGA read x
- ry  in  10  VGA read y
- colorCode  out  COLOR_W  pixel colour, 1-cycle latency

Behaviour:
- Reset: clk rising edge with reset==0. FSM goes to IDLE; busy=0, brush_ready=0 during reset and 1 the cycle after; colorCode=OUT_COLOR. RAM contents are not reset.
- FSM states: IDLE, PAINT, CLEAR.
- IDLE:
  - clear_req==1 -> CLEAR. Clear has priority over a simultaneous brush_valid; that stroke is not accepted (ready falls) and the host must hold it.
  - Otherwise brush_valid&&brush_ready -> latch colour and compute the clipped box. Clipping saturates, no wrap:
    - xs = max(brush_x - s, 0)
    - xe = min(brush_x + s, 2^CANVAS_BITS - 1)
    - ys and ye likewise.
    - Then go to PAINT with cursor at (xs, ys).
- PAINT:
  - Write latched colour at cursor, one pixel per cycle, x-major raster: x increments to xe, then wraps to xs with y+1.
  - After writing (xe, ye) -> IDLE.
  - Total cycles = (xe-xs+1)*(ye-ys+1).
  - brush_valid and clear_req are ignored; clear_req is not queued.
- CLEAR: write CLEAR_COLOR to addresses 0..2^(2*CANVAS_BITS)-1 sequentially, one per cycle, then -> IDLE.
- brush_ready = (state==IDLE) && !clear_req && reset.
- busy = state!=IDLE.
- Reset mid-PAINT or mid-CLEAR aborts the operation; pixels already written remain.
- RAM:
  - Address {y, x}.
  - One write port, one synchronous read port.
  - A same-cycle read/write to the same address returns the old data (read-first).
- Read path, stage 0:
  - Register rx and ry.
  - Issue RAM read at {ry[CANVAS_BITS-1:0], rx[CANVAS_BITS-1:0]}.
- Read path, stage 1, colorCode registered/aligned, priority order:
  1. rx_q >= 2^CANVAS_BITS or ry_q >= 2^CANVAS_BITS -> OUT_COLOR.
  2. GRID_PITCH!=0 and (rx_q%GRID_PITCH==0 or ry_q%GRID_PITCH==0), excluding 0 -> GRID_COLOR.
  3. Else RAM data.
- Latency: colorCode for (rx, ry) presented at edge N is valid after edge N+1.
- Grid modulo must not use a divider: track with per-axis pitch counters or a constant-compare table.

Decomposition:
- Shared package pixel_pkg:
  - Colour code constants (erase, red, green, blue, yellow, purple).
  - canvas_state_t enum {IDLE, PAINT, CLEAR}.
  - Default canvas and grid constants.
- One sub-module, canvas_ram: simple dual-port, read-first, parametrised address/data widths, no reset. Infers EBR.

Test Plan:
- Reset then clear_req pulse:
  - busy stays high exactly 16384 cycles, then falls.
  - Every in-canvas read returns 0, except grid lines at x or y = 50 or 100, which read 3'b101.
- Stroke at (10,20), size 1, colour 3'b010:
  - Nine writes in 9 PAINT cycles.
  - Reads at (9..11, 19..21) return 2.
  - (12,20) is unchanged.
- Stroke at (0,127), size 3:
  - Clipped to x 0..3, y 124..127: 16 cycles.
  - No write wraps to x=125 or y=0.
- Simultaneous clear_req and brush_valid in IDLE: CLEAR taken, brush_ready=0 that cycle; stroke accepted only after clear completes.
- Read rx=200, ry=5 -> OUT_COLOR one cycle later.
- Reset asserted at cycle 4 of a size-2 stroke: FSM IDLE next cycle, exactly 4 pixels written, brush_ready=1 after reset release.
